right_shift_rot_seq: RTL and testbench

Sequential right shift/rotate engine with a load/unload handshake and selectable mode. It is the opposite-direction companion to the team's left shift/rotate register. A word is accepted, moved right one bit per clock for a programmed number of steps, and then held until the result is consumed. It sits in the sequential building-block library and is used wherever a multi-cycle right rotate, logical shift or arithmetic shift is acceptable in place of a barrel shifter.

---
 rtl/right_shift_rot_pkg.sv | 16 +
 rtl/right_shift_step.sv | 30 +++
 rtl/right_shift_rot_seq.sv | 82 ++++++++
 tb/tb_right_shift_rot_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/right_shift_rot_pkg.sv
// Shared types and constants for the sequential right shift/rotate engine.
//   state_e : FSM encoding (idle, stepping, result held)
//   MODE_*  : mode select encodings; 2'b11 is reserved and behaves as rotate
package right_shift_rot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

endpackage

// File: rtl/right_shift_step.sv
// Combinational single-bit right step.
//   q       : current word
//   mode    : rotate / logical / arithmetic select
//   q_next  : word moved right by one position
//   ejected : bit leaving the LSB end
module right_shift_step
  import right_shift_rot_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q_next,
  output logic             ejected
);

  logic fill;

  always_comb begin
    fill = q[0];
    case (mode)
      MODE_LSR: fill = 1'b0;
      MODE_ASR: fill = q[WIDTH-1];
      default:  fill = q[0];
    endcase
    q_next  = {fill, q[WIDTH-1:1]};
    ejected = q[0];
  end

endmodule

// File: rtl/right_shift_rot_seq.sv
// Sequential right shift/rotate engine with load/unload handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : load handshake (data_in, amt, mode sampled on accept)
//   out_valid/out_ready : result handshake, q holds while out_valid
//   q                   : working/result register
//   shift_out           : bit ejected by the most recent step
//   busy                : steps in progress
module right_shift_rot_seq
  import right_shift_rot_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy
);

  state_e           state, state_nx;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] step_q;
  logic             step_ej;

  right_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .mode    (mode_r),
    .q_next  (step_q),
    .ejected (step_ej)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      q         <= '0;
      shift_out <= 1'b0;
      count     <= '0;
      mode_r    <= MODE_ROR;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            q      <= data_in;
            count  <= amt;
            mode_r <= mode;
          end
        end
        ST_SHIFT: begin
          q         <= step_q;
          shift_out <= step_ej;
          count     <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = (amt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (count == AMT_W'(1)) state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_SHIFT);

endmodule

// File: tb/tb_right_shift_rot_seq.sv
module tb_right_shift_rot_seq;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             shift_out;
  logic             busy;

  int n_cmp;
  int n_bad;

  right_shift_rot_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .shift_out (shift_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load one word, then count cycles until out_valid and how many sampled
  // cycles had busy high.
  task automatic run(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                     input logic [1:0] m, output int cycles, output int busy_cnt);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_load", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    data_in  = d;
    amt      = a;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '1;
    amt      = '1;
    mode     = 2'b01;
    cycles   = 0;
    busy_cnt = int'(busy);
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      busy_cnt += int'(busy);
    end
  endtask

  task automatic unload();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("unload_in_ready", {31'd0, in_ready}, 32'd1);
    check("unload_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int cyc, bc;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    amt       = '0;
    mode      = 2'b00;
    out_ready = 1'b0;
    #23;
    check("rst_q", {28'd0, q}, 32'h0);
    check("rst_shift_out", {31'd0, shift_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    // Rotate by one
    run(4'b1011, 3'd1, 2'b00, cyc, bc);
    check("ror1_lat", cyc, 32'd1);
    check("ror1_q", {28'd0, q}, 32'hD);
    check("ror1_so", {31'd0, shift_out}, 32'd1);
    unload();

    // Full rotation
    run(4'b1011, 3'd4, 2'b00, cyc, bc);
    check("ror4_lat", cyc, 32'd4);
    check("ror4_busy", bc, 32'd4);
    check("ror4_q", {28'd0, q}, 32'hB);
    check("ror4_so", {31'd0, shift_out}, 32'd1);
    unload();

    // Logical vs arithmetic
    run(4'b1011, 3'd2, 2'b01, cyc, bc);
    check("lsr2_q", {28'd0, q}, 32'h2);
    check("lsr2_so", {31'd0, shift_out}, 32'd1);
    unload();
    run(4'b1011, 3'd2, 2'b10, cyc, bc);
    check("asr2_q", {28'd0, q}, 32'hE);
    unload();

    // Reserved mode behaves as rotate
    run(4'b1011, 3'd1, 2'b11, cyc, bc);
    check("rsv1_q", {28'd0, q}, 32'hD);
    unload();

    // Zero amount and backpressure
    run(4'b0110, 3'd0, 2'b00, cyc, bc);
    check("amt0_lat", cyc, 32'd0);
    check("amt0_busy", bc, 32'd0);
    check("amt0_q", {28'd0, q}, 32'h6);
    repeat (5) @(posedge clk);
    #1;
    check("hold_q", {28'd0, q}, 32'h6);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    unload();

    // Over-range amounts
    run(4'b1000, 3'd7, 2'b00, cyc, bc);
    check("ror7_lat", cyc, 32'd7);
    check("ror7_q", {28'd0, q}, 32'h1);
    unload();
    run(4'b1000, 3'd7, 2'b01, cyc, bc);
    check("lsr7_q", {28'd0, q}, 32'h0);
    unload();
    run(4'b1000, 3'd7, 2'b10, cyc, bc);
    check("asr7_q", {28'd0, q}, 32'hF);
    unload();

    // Reset mid-operation
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = 4'b1011;
    amt      = 3'd3;
    mode     = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_q", {28'd0, q}, 32'h0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    run(4'b1011, 3'd1, 2'b00, cyc, bc);
    check("post_rst_lat", cyc, 32'd1);
    check("post_rst_q", {28'd0, q}, 32'hD);
    unload();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
